// File: rtl/ttl193_driver.sv
// ttl193_driver: turns UP/DOWN/LOAD/CLEAR commands into timed strobes for a
// chain of 74193 up/down counters, and synchronises the chain's carry, borrow
// and Q outputs back into the CP domain.
// Optional feature: define TTL193_DRIVER_SHADOW_EN to keep a shadow count that
// is checked against the synchronised chain Q after every completed command.
module ttl193_driver #(
  parameter int WIDTH    = 4,
  parameter int PULSE_LO = 1,
  parameter int PULSE_HI = 1
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_n,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             CPU_out,
  output logic             CPD_out,
  output logic             PL_bar_out,
  output logic             MR_out,
  output logic [WIDTH-1:0] D_out,
  input  logic             TCU_bar_in,
  input  logic             TCD_bar_in,
  input  logic [WIDTH-1:0] Q_in,
  output logic             done,
  output logic             carry_evt,
  output logic             borrow_evt,
  output logic             mismatch
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACT  = 2'd1;
  localparam logic [1:0] ST_REST = 2'd2;

  localparam logic [1:0] OP_UP  = 2'b00;
  localparam logic [1:0] OP_DN  = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [3:0] LO_LAST = 4'(PULSE_LO - 1);
  localparam logic [3:0] HI_LAST = 4'(PULSE_HI - 1);

  // strobe bundle order: {CPU, CPD, PL_bar, MR}
  localparam logic [3:0] STRB_IDLE = 4'b1110;

  logic [1:0] state;
  logic [1:0] op_q;
  logic [7:0] rem;
  logic [3:0] tmr;
  logic [3:0] strb;
  logic       cmpl;
  logic       accept;
  logic       n_zero;
  logic       act_end;
  logic       rest_end;

  // Active strobe pattern for each op; exactly one line leaves its idle level.
  function automatic logic [3:0] strb_for(input logic [1:0] op);
    case (op)
      OP_UP:   return 4'b0110;
      OP_DN:   return 4'b1010;
      OP_LD:   return 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign n_zero    = ~cmd_op[1] & (cmd_n == 8'd0);
  assign act_end   = (state == ST_ACT)  && (tmr == LO_LAST);
  assign rest_end  = (state == ST_REST) && (tmr == HI_LAST);

  assign {CPU_out, CPD_out, PL_bar_out, MR_out} = strb;

  // Command FSM; strobes are flops so reset drops them inactive immediately.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= ST_IDLE;
      op_q  <= OP_UP;
      rem   <= '0;
      tmr   <= '0;
      strb  <= STRB_IDLE;
      cmpl  <= 1'b0;
      D_out <= '0;
    end else begin
      cmpl <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            rem  <= cmd_n;
            tmr  <= '0;
            if (cmd_op == OP_LD) D_out <= cmd_data;
            if (n_zero) begin
              cmpl <= 1'b1;
            end else begin
              state <= ST_ACT;
              strb  <= strb_for(cmd_op);
            end
          end
        end
        ST_ACT: begin
          if (act_end) begin
            // strobe release is the counting edge seen by the chain
            state <= ST_REST;
            tmr   <= '0;
            strb  <= STRB_IDLE;
            if (!op_q[1]) rem <= rem - 8'd1;
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        ST_REST: begin
          if (rest_end) begin
            tmr <= '0;
            if (!op_q[1] && (rem != 8'd0)) begin
              state <= ST_ACT;
              strb  <= strb_for(op_q);
            end else begin
              state <= ST_IDLE;
              cmpl  <= 1'b1;
            end
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          strb  <= STRB_IDLE;
        end
      endcase
    end
  end

  // done trails completion by one cycle so n=0 and n>0 share the same offset.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) done <= 1'b0;
    else    done <= cmpl;
  end

  logic [1:0] tcu_s;
  logic [1:0] tcd_s;
  logic       tcu_d;
  logic       tcd_d;

  // Two-flop synchronisers on carry/borrow plus falling-edge pulse detect.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      tcu_s      <= 2'b11;
      tcd_s      <= 2'b11;
      tcu_d      <= 1'b1;
      tcd_d      <= 1'b1;
      carry_evt  <= 1'b0;
      borrow_evt <= 1'b0;
    end else begin
      tcu_s      <= {tcu_s[0], TCU_bar_in};
      tcd_s      <= {tcd_s[0], TCD_bar_in};
      tcu_d      <= tcu_s[1];
      tcd_d      <= tcd_s[1];
      carry_evt  <= tcu_d & ~tcu_s[1];
      borrow_evt <= tcd_d & ~tcd_s[1];
    end
  end

`ifdef TTL193_DRIVER_SHADOW_EN
  logic [WIDTH-1:0] q_s0;
  logic [WIDTH-1:0] q_s1;
  logic [WIDTH-1:0] shadow;
  logic [1:0]       chk_pipe;
  logic             mm_q;

  assign mismatch = mm_q;

  // Shadow follows each counting edge; compare lands three cycles after done,
  // giving the chain Q time to cross the synchroniser.
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      q_s0     <= '0;
      q_s1     <= '0;
      shadow   <= '0;
      chk_pipe <= '0;
      mm_q     <= 1'b0;
    end else begin
      q_s0     <= Q_in;
      q_s1     <= q_s0;
      chk_pipe <= {chk_pipe[0], done};
      if (act_end) begin
        case (op_q)
          OP_UP:   shadow <= shadow + 1'b1;
          OP_DN:   shadow <= shadow - 1'b1;
          OP_LD:   shadow <= D_out;
          default: shadow <= '0;
        endcase
      end
      if (chk_pipe[1] && (q_s1 != shadow)) mm_q <= 1'b1;
    end
  end
`else
  logic unused_q;

  assign unused_q = ^Q_in;
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_ttl193_driver.sv
// tb_ttl193_driver: directed bench with a behavioural 74193 chain model.
module tb_ttl193_driver;
  logic       CP = 1'b0;
  logic       MR = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_n = 8'd0;
  logic [3:0] cmd_data = 4'h0;
  logic       CPU_out, CPD_out, PL_bar_out, MR_out;
  logic [3:0] D_out;
  logic       TCU_bar_in, TCD_bar_in;
  logic [3:0] Q_in;
  logic       done, carry_evt, borrow_evt, mismatch;

  logic       b_valid = 1'b0;
  logic       b_ready;
  logic       b_cpu, b_cpd, b_pl, b_mr;
  logic [3:0] b_d;
  logic       b_done, b_carry, b_borrow, b_mm;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CP = ~CP;

  ttl193_driver #(.WIDTH(4), .PULSE_LO(1), .PULSE_HI(1)) dut (
    .CP(CP), .MR(MR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_n(cmd_n), .cmd_data(cmd_data),
    .CPU_out(CPU_out), .CPD_out(CPD_out), .PL_bar_out(PL_bar_out),
    .MR_out(MR_out), .D_out(D_out), .TCU_bar_in(TCU_bar_in),
    .TCD_bar_in(TCD_bar_in), .Q_in(Q_in), .done(done),
    .carry_evt(carry_evt), .borrow_evt(borrow_evt), .mismatch(mismatch));

  ttl193_driver #(.WIDTH(4), .PULSE_LO(3), .PULSE_HI(2)) dut_b (
    .CP(CP), .MR(MR), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_op(2'b01), .cmd_n(8'd4), .cmd_data(4'h0),
    .CPU_out(b_cpu), .CPD_out(b_cpd), .PL_bar_out(b_pl),
    .MR_out(b_mr), .D_out(b_d), .TCU_bar_in(1'b1),
    .TCD_bar_in(1'b1), .Q_in(4'h0), .done(b_done),
    .carry_evt(b_carry), .borrow_evt(b_borrow), .mismatch(b_mm));

  // behavioural 74193: counts on strobe rising edges, load/clear applied
  logic [3:0] mq = 4'h0;
  logic pcu = 1'b1, pcd = 1'b1, ppl = 1'b1;
  logic force_q = 1'b0;
  always @(CPU_out or CPD_out or PL_bar_out or MR_out) begin
    if (MR_out) mq = 4'h0;
    else if (PL_bar_out && !ppl) mq = D_out;
    else if (CPU_out && !pcu && CPD_out) mq = mq + 4'h1;
    else if (CPD_out && !pcd && CPU_out) mq = mq - 4'h1;
    pcu = CPU_out;
    pcd = CPD_out;
    ppl = PL_bar_out;
  end
  assign TCU_bar_in = !(!CPU_out && (mq == 4'hF));
  assign TCD_bar_in = !(!CPD_out && (mq == 4'h0));
  assign Q_in = force_q ? 4'h4 : mq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // issue one command to dut and observe until a few cycles past done
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] n, input logic [3:0] data,
                         output int lat, output int pulses, output int lowc, output int other,
                         output int carry, output int borrow, output int viol, output int mmc);
    logic st, prev;
    int lim;
    lat = -1; pulses = 0; lowc = 0; other = 0; carry = 0; borrow = 0; viol = 0; mmc = -1;
    prev = 1'b0;
    lim = 2 * int'(n) + 12;
    cmd_op = op; cmd_n = n; cmd_data = data; cmd_valid = 1'b1;
    @(posedge CP); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < lim; c++) begin
      if (c > 0) begin @(posedge CP); #1; end
      case (op)
        2'b00: begin st = !CPU_out;    if (!CPD_out || !PL_bar_out || MR_out) other++; end
        2'b01: begin st = !CPD_out;    if (!CPU_out || !PL_bar_out || MR_out) other++; end
        2'b10: begin st = !PL_bar_out; if (!CPU_out || !CPD_out || MR_out) other++; end
        default: begin st = MR_out;    if (!CPU_out || !CPD_out || !PL_bar_out) other++; end
      endcase
      if (st && !prev) pulses++;
      if (st) lowc++;
      prev = st;
      if (!CPU_out && !CPD_out) viol++;
      if ((!PL_bar_out || MR_out) && (!CPU_out || !CPD_out)) viol++;
      if (done) begin
        if (lat < 0) lat = c;
        else viol++;
      end
      if (carry_evt) carry++;
      if (borrow_evt) borrow++;
      if (mismatch && mmc < 0) mmc = c;
      if (lat >= 0 && c >= lat + 4) break;
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] n;
    logic [3:0] data;
    int         lat;
    int         pulses;
    logic [3:0] q;
    int         carry;
    int         borrow;
  } vec_t;

  vec_t vt[8];

  initial begin
    int lat, pulses, lowc, other, carry, borrow, viol, mmc;
    logic [3:0] exp_d;
    logic [19:0] obs, exp_pat;
    int b_lat, b_other;

    vt[0] = '{2'b10, 8'd0, 4'hE, 3,  1, 4'hE, 0, 0};
    vt[1] = '{2'b00, 8'd3, 4'h0, 7,  3, 4'h1, 1, 0};
    vt[2] = '{2'b11, 8'd0, 4'h7, 3,  1, 4'h0, 0, 0};
    vt[3] = '{2'b01, 8'd1, 4'h0, 3,  1, 4'hF, 0, 1};
    vt[4] = '{2'b00, 8'd0, 4'h9, 1,  0, 4'hF, 0, 0};
    vt[5] = '{2'b10, 8'd9, 4'h3, 3,  1, 4'h3, 0, 0};
    vt[6] = '{2'b01, 8'd5, 4'h0, 11, 5, 4'hE, 0, 1};
    vt[7] = '{2'b00, 8'd2, 4'h0, 5,  2, 4'h0, 1, 0};

    // reset state
    repeat (3) @(posedge CP);
    #1;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_strobes", {CPU_out, CPD_out, PL_bar_out, MR_out}, 4'b1110);
    chk("rst_d", D_out, 0);
    chk("rst_done", done, 0);
    chk("rst_evts", {carry_evt, borrow_evt}, 0);
    chk("rst_mismatch", mismatch, 0);
    MR = 1'b0;
    @(posedge CP); #1;

    // table-driven commands on the default-timing instance
    exp_d = 4'h0;
    for (int i = 0; i < 8; i++) begin
      run_cmd(vt[i].op, vt[i].n, vt[i].data, lat, pulses, lowc, other, carry, borrow, viol, mmc);
      if (vt[i].op == 2'b10) exp_d = vt[i].data;
      chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
      chk($sformatf("v%0d_pulses", i), pulses, vt[i].pulses);
      chk($sformatf("v%0d_active_cycles", i), lowc, vt[i].pulses);
      chk($sformatf("v%0d_other_strobes", i), other, 0);
      chk($sformatf("v%0d_exclusion", i), viol, 0);
      chk($sformatf("v%0d_chain_q", i), mq, vt[i].q);
      chk($sformatf("v%0d_carry", i), carry, vt[i].carry);
      chk($sformatf("v%0d_borrow", i), borrow, vt[i].borrow);
      chk($sformatf("v%0d_d_out", i), D_out, exp_d);
      chk($sformatf("v%0d_mismatch", i), mismatch, 0);
      chk($sformatf("v%0d_ready", i), cmd_ready, 1);
    end

    // PULSE_LO=3 / PULSE_HI=2 instance: DOWN n=4
    exp_pat = '0;
    for (int c = 0; c < 20; c++) exp_pat[c] = ((c % 5) < 3);
    obs = '0; b_lat = -1; b_other = 0;
    b_valid = 1'b1;
    @(posedge CP); #1;
    b_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin @(posedge CP); #1; end
      if (c < 20) obs[c] = !b_cpd;
      else if (!b_cpd) b_other++;
      if (!b_cpu || !b_pl || b_mr) b_other++;
      if (b_done && b_lat < 0) b_lat = c;
    end
    chk("b_cpd_pattern", obs, exp_pat);
    chk("b_latency", b_lat, 21);
    chk("b_other_strobes", b_other, 0);

    // abort UP n=5 during its second pulse
    cmd_op = 2'b00; cmd_n = 8'd5; cmd_valid = 1'b1;
    @(posedge CP); #1;
    cmd_valid = 1'b0;
    @(posedge CP); #1;
    @(posedge CP); #1;
    chk("abort_in_pulse", CPU_out, 0);
    #2 MR = 1'b1;
    #1;
    chk("abort_strobes", {CPU_out, CPD_out, PL_bar_out, MR_out}, 4'b1110);
    chk("abort_ready", cmd_ready, 1);
    #2 MR = 1'b0;
    other = 0; lat = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge CP); #1;
      if (done) lat++;
      if (!CPU_out || !CPD_out || !PL_bar_out || MR_out) other++;
    end
    chk("abort_no_done", lat, 0);
    chk("abort_quiet", other, 0);
    chk("abort_ready_after", cmd_ready, 1);

    // chain returns Q=4 while LOAD 5 is issued
    force_q = 1'b1;
    run_cmd(2'b10, 8'd0, 4'h5, lat, pulses, lowc, other, carry, borrow, viol, mmc);
    chk("mm_latency", lat, 3);
`ifdef TTL193_DRIVER_SHADOW_EN
    chk("mm_first_cycle", mmc, 6);
`else
    chk("mm_first_cycle", mmc, -1);
`endif
    repeat (4) @(posedge CP);
    #1;
`ifdef TTL193_DRIVER_SHADOW_EN
    chk("mm_sticky", mismatch, 1);
`else
    chk("mm_sticky", mismatch, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ttl193_driver.md
TTL193_DRIVER -- requirements
Module: ttl193_driver

Interface
REQ-001 Parameter WIDTH, default 4: width of the driven 74193 data bus and of the shadow count.
REQ-002 Parameter PULSE_LO, default 1: cycles each strobe is held in its active level (range 1..15).
REQ-003 Parameter PULSE_HI, default 1: cycles of inactive level after each strobe before the next one (range 1..15).
REQ-004 Ports, clock and reset first:
- CP  in  1  system clock, rising edge.
- MR  in  1  asynchronous master reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at CP rise.
- cmd_op  in  2  00 UP, 01 DOWN, 10 LOAD, 11 CLEAR.
- cmd_n  in  8  pulse count for UP/DOWN; ignored otherwise.
- cmd_data  in  WIDTH  load value for LOAD.
- CPU_out  out  1  count-up clock to chain.
- CPD_out  out  1  count-down clock to chain.
- PL_bar_out  out  1  parallel load to chain, active-low.
- MR_out  out  1  clear to chain, active-high.
- D_out  out  WIDTH  parallel data to chain.
- TCU_bar_in  in  1  carry from chain, asynchronous.
- TCD_bar_in  in  1  borrow from chain, asynchronous.
- Q_in  in  WIDTH  chain outputs, asynchronous.
- done  out  1  one-cycle pulse when a command completes.
- carry_evt  out  1  one-cycle pulse per synchronised TCU_bar falling edge.
- borrow_evt  out  1  one-cycle pulse per synchronised TCD_bar falling edge.
- mismatch  out  1  sticky shadow/chain disagreement.

Function
REQ-005 FSM states IDLE, ACT, REST; cmd_ready SHALL be 1 only in IDLE.
REQ-006 Accept in IDLE: latch op, n, data; drive D_out = cmd_data on LOAD; go to ACT, or for UP/DOWN with cmd_n = 0 pulse done next cycle and stay in IDLE.
REQ-007 ACT (PULSE_LO cycles): UP drives CPU_out 0; DOWN drives CPD_out 0; LOAD drives PL_bar_out 0; CLEAR drives MR_out 1; all other strobes stay inactive.
REQ-008 REST (PULSE_HI cycles): all strobes inactive (CPU_out, CPD_out, PL_bar_out 1; MR_out 0); the strobe's return to inactive is the counting edge.
REQ-009 UP/DOWN: remaining count decrements at each ACT->REST; after REST, go to ACT if remaining > 0, else IDLE with done = 1 for one cycle.
REQ-010 LOAD/CLEAR: exactly one ACT+REST, then IDLE with done.
REQ-011 Only one of CPU_out/CPD_out SHALL ever be 0; both SHALL be 1 whenever PL_bar_out = 0 or MR_out = 1.
REQ-012 UP/DOWN pulse period SHALL be exactly PULSE_LO + PULSE_HI cycles; n pulses complete n*(PULSE_LO+PULSE_HI) cycles after accept, done in the following cycle.
REQ-013 D_out SHALL hold its last loaded value until the next LOAD.
REQ-014 TCU_bar_in, TCD_bar_in, Q_in SHALL pass through two-flop synchronisers; carry_evt/borrow_evt assert one cycle after a synchronised 1->0 transition is seen, independent of FSM state.
REQ-015 cmd_valid while not IDLE SHALL be ignored; no command queueing.

Reset
REQ-016 MR high SHALL asynchronously force: state IDLE, cmd_ready 1, CPU_out 1, CPD_out 1, PL_bar_out 1, MR_out 0, D_out 0, done 0, carry_evt 0, borrow_evt 0, mismatch 0, synchronisers 1 for TCU/TCD and 0 for Q, shadow 0.
REQ-017 MR mid-command SHALL abort it with no done pulse; a strobe in progress returns inactive immediately.

Configuration
REQ-018 Macro TTL193_DRIVER_SHADOW_EN defined: a WIDTH-bit shadow tracks the chain (LOAD -> data, CLEAR -> 0, UP +1, DOWN -1 modulo 2^WIDTH at each ACT->REST); three cycles after done, synchronised Q_in is compared to shadow and any difference sets mismatch until MR.
REQ-019 Macro undefined: no shadow logic, mismatch tied 0, Q_in unused.

Verification
REQ-020 LOAD cmd_data=4'hE, then UP n=3, default pulses -> PL_bar_out low 1 cycle, D_out=E; three CPU_out low pulses with period 2; chain model 1,...; one carry_evt; done after UP.
REQ-021 CLEAR then DOWN n=1 -> MR_out high 1 cycle; one CPD_out pulse; borrow_evt once; model Q=F.
REQ-022 UP n=0 -> no strobe activity, done exactly one cycle after accept.
REQ-023 PULSE_LO=3, PULSE_HI=2, DOWN n=4 -> CPD_out low 3, high 2, four times; done 21 cycles after accept.
REQ-024 MR asserted during 2nd pulse of UP n=5 -> all strobes inactive same cycle, no done, cmd_ready 1 after release.
REQ-025 With TTL193_DRIVER_SHADOW_EN, LOAD 5 into model wired to return Q=4 -> mismatch 1 three cycles after done; with macro undefined mismatch stays 0.
